data_sram_resp: RTL and testbench

//  Responder end of the CPU data-SRAM interface. Services M-stage loads/stores

---
 rtl/data_sram_resp_pkg.sv | 21 ++
 rtl/data_sram_resp_bram_be.sv | 38 +++
 rtl/data_sram_resp.sv | 99 +++++++++
 tb/tb_data_sram_resp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the CPU data-SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [1:0] {
    DRS_IDLE = 2'd0,
    DRS_WAIT = 2'd1,
    DRS_DONE = 2'd2
  } drs_state_e;

  // Write payload held for the duration of the access.
  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } drs_wr_t;

endpackage

// File: rtl/data_sram_resp_bram_be.sv
// Single-port byte-writable word RAM with synchronous read/write.
// The read output register holds until the next read and doubles as rdata.
module data_sram_resp_bram_be
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BE_W-1:0]   we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (we_i[b]) begin
        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Responder for the CPU data-SRAM port: stalls the pipeline for a fixed number
// of wait states per access and holds read data until the pipeline moves on.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              memen_i,
  input  logic [BE_W-1:0]   wen_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              cpu_stall_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              d_stall_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WAIT_CYCLES);

  drs_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  drs_wr_t           req_q, req_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [BE_W-1:0]   ram_we_c;
  logic              ram_re_c;

  // Byte offset and bits above the RAM depth are ignored (aliasing wrap).
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DRS_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    waddr_d   = waddr_q;
    ram_we_c  = '0;
    ram_re_c  = 1'b0;
    d_stall_o = 1'b0;
    unique case (state_q)
      DRS_IDLE: begin
        // Reset state is IDLE, so gating here keeps the stall low during reset.
        d_stall_o = memen_i & rst_ni;
        if (memen_i) begin
          req_d.be   = wen_i;
          req_d.data = wdata_i;
          waddr_d    = addr_i[ADDR_W+1:2];
          cnt_d      = '0;
          state_d    = DRS_WAIT;
        end
      end
      DRS_WAIT: begin
        d_stall_o = 1'b1;
        if (cnt_q == CntLast) begin
          ram_we_c = req_q.be;
          ram_re_c = (req_q.be == '0);
          state_d  = DRS_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRS_DONE: begin
        // The held M-stage request is never re-issued while the pipeline waits.
        if (!cpu_stall_i) begin
          state_d = DRS_IDLE;
        end
      end
      default: state_d = DRS_IDLE;
    endcase
  end

  data_sram_resp_bram_be #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ram_we_c),
    .re_i    (ram_re_c),
    .addr_i  (waddr_q),
    .wdata_i (req_q.data),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: three builds (0, 1, 3 wait states)
// checked against a word-array model of the RAM and the stall-length rule.
module tb_data_sram_resp;

  localparam int unsigned ADDR_W = 10;
  localparam int NDUT = 3;

  logic        clk;
  logic        rst_n;
  logic        memen     [NDUT];
  logic [3:0]  wen       [NDUT];
  logic [31:0] addr      [NDUT];
  logic [31:0] wdata     [NDUT];
  logic        cpu_stall [NDUT];
  logic [31:0] rdata     [NDUT];
  logic        d_stall   [NDUT];

  int          wc     [NDUT];
  logic [31:0] mdl    [NDUT][1024];
  logic [31:0] exp_rd [NDUT];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .memen_i(memen[0]), .wen_i(wen[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .cpu_stall_i(cpu_stall[0]),
    .rdata_o(rdata[0]), .d_stall_o(d_stall[0]));

  data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .memen_i(memen[1]), .wen_i(wen[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .cpu_stall_i(cpu_stall[1]),
    .rdata_o(rdata[1]), .d_stall_o(d_stall[1]));

  data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .memen_i(memen[2]), .wen_i(wen[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .cpu_stall_i(cpu_stall[2]),
    .rdata_o(rdata[2]), .d_stall_o(d_stall[2]));

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One request from an idle port; returns stall length and rdata in the first non-stalled cycle.
  task automatic do_req(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic cs,
                        output int n, output logic [31:0] rd);
    @(negedge clk);
    memen[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d; cpu_stall[k] = cs;
    #1;
    n = 0;
    while (d_stall[k] === 1'b1 && n < 64) begin
      n++;
      @(negedge clk); #1;
    end
    memen[k] = 1'b0;
    rd = rdata[k];
    if (w != 4'h0) mdl[k][widx(a)] = merge(mdl[k][widx(a)], w, d);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) begin
      memen[k] = 1'b1; wen[k] = 4'h0; addr[k] = 32'h10; wdata[k] = '0; cpu_stall[k] = 1'b0;
    end
    #3 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (d_stall[k] !== 1'b0) begin
          errors++; $display("FAIL reset_d_stall dut%0d cyc%0d got %b exp 0", k, c, d_stall[k]);
        end
        checks++;
        if (rdata[k] !== 32'h0) begin
          errors++; $display("FAIL reset_rdata dut%0d cyc%0d got %h exp 0", k, c, rdata[k]);
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      memen[k] = 1'b0; exp_rd[k] = '0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int n; logic [31:0] rd;
    for (int k = 0; k < NDUT; k++) begin
      do_req(k, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, n, rd);
      checks++;
      if (n != wc[k] + 2) begin
        errors++; $display("FAIL sw_stall_len dut%0d got %0d exp %0d", k, n, wc[k] + 2);
      end
      checks++;
      if (rd !== exp_rd[k]) begin
        errors++; $display("FAIL sw_rdata_held dut%0d got %h exp %h", k, rd, exp_rd[k]);
      end
      do_req(k, 4'h0, 32'h10, 32'h0, 1'b0, n, rd);
      exp_rd[k] = 32'hDEADBEEF;
      checks++;
      if (n != wc[k] + 2) begin
        errors++; $display("FAIL lw_stall_len dut%0d got %0d exp %0d", k, n, wc[k] + 2);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
        errors++; $display("FAIL lw_rdata dut%0d got %h exp deadbeef", k, rd);
      end
    end
  endtask

  task automatic test_byte_store();
    int n; logic [31:0] rd;
    for (int k = 0; k < NDUT; k++) begin
      do_req(k, 4'hF, 32'h20, 32'h11223344, 1'b0, n, rd);
      do_req(k, 4'b0100, 32'h20, 32'h00AA0000, 1'b0, n, rd);
      do_req(k, 4'h0, 32'h20, 32'h0, 1'b0, n, rd);
      exp_rd[k] = 32'h11AA3344;
      checks++;
      if (rd !== 32'h11AA3344) begin
        errors++; $display("FAIL byte_store dut%0d got %h exp 11aa3344", k, rd);
      end
    end
  endtask

  task automatic test_cpu_stall();
    int n; logic [31:0] rd;
    int k = 1;
    do_req(k, 4'hF, 32'h40, 32'hCAFEF00D, 1'b0, n, rd);
    do_req(k, 4'h0, 32'h40, 32'h0, 1'b1, n, rd);
    exp_rd[k] = 32'hCAFEF00D;
    // A different store presented while held in DONE must not be performed.
    memen[k] = 1'b1; wen[k] = 4'hF; addr[k] = 32'h40; wdata[k] = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (d_stall[k] !== 1'b0) begin
        errors++; $display("FAIL hold_d_stall cyc%0d got %b exp 0", c, d_stall[k]);
      end
      checks++;
      if (rdata[k] !== 32'hCAFEF00D) begin
        errors++; $display("FAIL hold_rdata cyc%0d got %h exp cafef00d", c, rdata[k]);
      end
      @(negedge clk); #1;
    end
    memen[k] = 1'b0; cpu_stall[k] = 1'b0;
    do_req(k, 4'h0, 32'h40, 32'h0, 1'b0, n, rd);
    checks++;
    if (n != wc[k] + 2) begin
      errors++; $display("FAIL release_stall_len got %0d exp %0d", n, wc[k] + 2);
    end
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL no_reissue got %h exp cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] rd;
    for (int k = 0; k < NDUT; k++) begin
      do_req(k, 4'hF, 32'h50, 32'hA5A5_0001, 1'b0, n, rd);
      do_req(k, 4'hF, 32'h54, 32'h5A5A_0002, 1'b0, n, rd);
      @(negedge clk);
      memen[k] = 1'b1; wen[k] = 4'h0; addr[k] = 32'h50;
      #1; n = 0;
      while (d_stall[k] === 1'b1 && n < 64) begin n++; @(negedge clk); #1; end
      addr[k] = 32'h54;
      checks++;
      if (rdata[k] !== 32'hA5A5_0001 || n != wc[k] + 2) begin
        errors++; $display("FAIL b2b_first dut%0d got %h/%0d exp a5a50001/%0d", k, rdata[k], n, wc[k] + 2);
      end
      @(negedge clk); #1;
      n = 0;
      while (d_stall[k] === 1'b1 && n < 64) begin n++; @(negedge clk); #1; end
      memen[k] = 1'b0;
      exp_rd[k] = 32'h5A5A_0002;
      checks++;
      if (rdata[k] !== 32'h5A5A_0002 || n != wc[k] + 2) begin
        errors++; $display("FAIL b2b_second dut%0d got %h/%0d exp 5a5a0002/%0d", k, rdata[k], n, wc[k] + 2);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n; logic [31:0] rd;
    for (int k = 0; k < NDUT; k++) begin
      do_req(k, 4'hF, 32'h30, 32'h0, 1'b0, n, rd);
      @(negedge clk);
      memen[k] = 1'b1; wen[k] = 4'hF; addr[k] = 32'h30; wdata[k] = 32'h55;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (d_stall[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        errors++; $display("FAIL midwait_reset dut%0d got %b/%h exp 0/0", k, d_stall[k], rdata[k]);
      end
      memen[k] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < NDUT; j++) exp_rd[j] = '0;
      do_req(k, 4'h0, 32'h30, 32'h0, 1'b0, n, rd);
      exp_rd[k] = mdl[k][widx(32'h30)];
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL midwait_abandon dut%0d got %h exp 0", k, rd);
      end
    end
  endtask

  task automatic test_alias();
    int n; logic [31:0] rd; logic [31:0] v;
    for (int k = 0; k < NDUT; k++) begin
      v = $urandom;
      do_req(k, 4'hF, 32'h10 + (32'd4 << ADDR_W), v, 1'b0, n, rd);
      do_req(k, 4'h0, 32'h10, 32'h0, 1'b0, n, rd);
      exp_rd[k] = v;
      checks++;
      if (rd !== v) begin
        errors++; $display("FAIL alias_wrap dut%0d got %h exp %h", k, rd, v);
      end
      do_req(k, 4'h0, 32'hFFFF_F013, 32'h0, 1'b0, n, rd);
      checks++;
      if (rd !== v) begin
        errors++; $display("FAIL alias_high_low dut%0d got %h exp %h", k, rd, v);
      end
    end
  endtask

  task automatic test_random();
    int n; int wi; logic [31:0] rd; logic [3:0] w; logic [31:0] a; logic [31:0] d;
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++) do_req(k, 4'hF, 32'((64 + i) << 2), $urandom, 1'b0, n, rd);
      for (int t = 0; t < 40; t++) begin
        w  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        wi = 64 + int'($urandom_range(0, 15));
        a  = ($urandom & 32'hFFFF_F000) | 32'(wi << 2) | ($urandom & 32'h3);
        d  = $urandom;
        do_req(k, w, a, d, 1'b0, n, rd);
        checks++;
        if (n != wc[k] + 2) begin
          errors++; $display("FAIL rand_stall_len dut%0d op%0d got %0d exp %0d", k, t, n, wc[k] + 2);
        end
        if (w == 4'h0) exp_rd[k] = mdl[k][wi];
        checks++;
        if (rd !== exp_rd[k]) begin
          errors++; $display("FAIL rand_rdata dut%0d op%0d wen %h addr %h got %h exp %h",
                             k, t, w, a, rd, exp_rd[k]);
        end
      end
    end
  endtask

  initial begin
    wc[0] = 0; wc[1] = 1; wc[2] = 3;
    rst_n = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      memen[k] = 1'b0; wen[k] = '0; addr[k] = '0; wdata[k] = '0; cpu_stall[k] = 1'b0;
      exp_rd[k] = '0;
      for (int i = 0; i < 1024; i++) mdl[k][i] = '0;
    end
    test_reset();
    test_store_load();
    test_byte_store();
    test_cpu_stall();
    test_back_to_back();
    test_reset_mid_wait();
    test_alias();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
